// File: rtl/add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// add_seq_ctrl
//   Performs an NBYTES-wide add or subtract by stepping a single shared 8-bit
//   ripple adder over the operands one byte per cycle, least significant byte
//   first. Operands are captured when a request is accepted; the carry between
//   byte steps is held in a register. When the last byte completes, the block
//   reports result, carry out and signed overflow together with a one-cycle
//   done pulse.
//
//   Subtraction is A + ~B + 1: B is inverted at capture time and the carry
//   register is seeded with 1.
//
// Ports
//   clk        in   1  system clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   start      in   1  request, sampled only in IDLE
//   sub        in   1  0: A+B, 1: A-B (sampled with start)
//   op_a       in   W  operand A (sampled with start)
//   op_b       in   W  operand B (sampled with start)
//   busy       out  1  high while bytes are being processed
//   done       out  1  one-cycle pulse, result and flags valid
//   result     out  W  sum / difference
//   carry_out  out  1  carry out of the MSB (for sub: 1 = no borrow)
//   overflow   out  1  two's-complement signed overflow
// -----------------------------------------------------------------------------

// 8-bit ripple-carry adder built from bit-level full-adder equations.
module full_adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);

  logic [8:0] c;

  // NOTE: every variable written in always_comb is given a value first, so no
  // path through the block can leave it holding its old value (a latch).
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[8];
  end

endmodule

module add_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                sub,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] result,
  output logic                carry_out,
  output logic                overflow
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  // Bit offset of the current byte is {cnt, 3'b000}.
  localparam int LW = CW + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q;
  logic           carry_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;   // already inverted for subtraction

  logic           accept;
  logic           last_byte;
  logic [LW-1:0]  lsb;
  logic [7:0]     add_a;
  logic [7:0]     add_b;
  logic [7:0]     add_sum;
  logic           add_cout;

  assign accept    = (state_q == S_IDLE) && start;
  assign last_byte = (cnt_q == CW'(NBYTES - 1));
  assign lsb       = {cnt_q, 3'b000};
  assign add_a     = a_q[lsb +: 8];
  assign add_b     = b_q[lsb +: 8];

  full_adder_8bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Outputs are decodes of the state register only; no input reaches them
  // combinationally.
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start)     state_d = S_RUN;
      S_RUN:   if (last_byte) state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;
      default:                state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q   <= '0;
        carry_q <= sub;
      end else if (state_q == S_RUN) begin
        result[lsb +: 8] <= add_sum;
        carry_q          <= add_cout;
        cnt_q            <= cnt_q + CW'(1);
        if (last_byte) begin
          carry_out <= add_cout;
          overflow  <= (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
        end
      end
    end
  end

  // NOTE: the operand holding registers carry no reset; they are always
  // written on accept before being read, so resetting them adds nothing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= op_a;
      b_q <= sub ? ~op_b : op_b;
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_add_seq_ctrl
//   Directed bench for add_seq_ctrl with NBYTES=4. Inputs are driven and
//   outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_add_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  add_seq_ctrl #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: plain wide arithmetic. Returns {ovf, carry, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s);
    logic [W-1:0] bp;
    logic [W:0]   full;
    logic         v;
    bp   = s ? ~b : b;
    full = {1'b0, a} + {1'b0, bp} + {{W{1'b0}}, s};
    v    = (a[W-1] == bp[W-1]) && (full[W-1] != a[W-1]);
    return {v, full[W], full[W-1:0]};
  endfunction

  // One transaction. Request is raised for one cycle; optionally a second
  // request with other operands is poked in during RUN (must be ignored).
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_r, input logic exp_c,
                        input logic exp_v, input bit poke);
    int n;
    int busy_cnt;
    int extra_done;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; start = 1'b1;
    @(negedge clk);   // accept edge has passed
    start = 1'b0;
    n = 1; busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      if (poke && n == 2) begin
        start = 1'b1; op_a = ~a; op_b = a ^ b; sub = ~s;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check({name, "_done_latency"}, 64'(n), 64'(NB + 1));
    check({name, "_busy_cycles"}, 64'(busy_cnt), 64'(NB));
    check({name, "_busy_at_done"}, 64'(busy), 64'd0);
    check({name, "_result"}, 64'(result), 64'(exp_r));
    check({name, "_carry"}, 64'(carry_out), 64'(exp_c));
    check({name, "_overflow"}, 64'(overflow), 64'(exp_v));
    @(negedge clk);
    check({name, "_done_pulse"}, 64'(done), 64'd0);
    if (poke) begin
      extra_done = 0;
      for (int i = 0; i < 8; i++) begin
        if (done || busy) extra_done++;
        @(negedge clk);
      end
      check({name, "_no_second_op"}, 64'(extra_done), 64'd0);
      check({name, "_result_held"}, 64'(result), 64'(exp_r));
    end
  endtask

  logic [W-1:0] ra [3];
  logic [W-1:0] rb [3];
  logic         rs [3];

  initial begin
    logic [W+1:0] m;
    int           n;
    start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({carry_out, overflow}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1..T3: hand-computed vectors
    run_op("t1",  32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("t2",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
    run_op("t3a", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("t3b", 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);

    // T4: second request during RUN is ignored
    run_op("t4",  32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b1);

    // T5: async reset in RUN cycle k=2
    @(negedge clk);
    op_a = 32'hAAAA_AAAA; op_b = 32'h5555_5555; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);   // now in cycle k=2
    rst_n = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_result", 64'(result), 64'd0);
    check("t5_flags", 64'({carry_out, overflow}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) n++;
      @(negedge clk);
    end
    check("t5_no_done_after_abort", 64'(n), 64'd0);
    run_op("t5_retry", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

    // T6: start held high, back-to-back operations
    for (int i = 0; i < 3; i++) begin
      ra[i] = $urandom; rb[i] = $urandom; rs[i] = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    op_a = ra[0]; op_b = rb[0]; sub = rs[0]; start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done && n < 20);
      check($sformatf("t6_%0d_spacing", i), 64'(n), (i == 0) ? 64'(NB + 1) : 64'(NB + 2));
      m = model(ra[i], rb[i], rs[i]);
      check($sformatf("t6_%0d_result", i), 64'(result), 64'(m[W-1:0]));
      check($sformatf("t6_%0d_carry", i), 64'(carry_out), 64'(m[W]));
      check($sformatf("t6_%0d_overflow", i), 64'(overflow), 64'(m[W+1]));
      if (i < 2) begin
        op_a = ra[i+1]; op_b = rb[i+1]; sub = rs[i+1];
      end
    end
    start = 1'b0;
    repeat (NB + 3) @(negedge clk);
    check("t6_idle_after", 64'({busy, done}), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
